// File: rtl/nios_ii_system_cpu_div_cell.sv
// Nios II multicycle divider: 32-bit restoring shift-subtract, signed/unsigned.
// Fixed 34-cycle latency from start sample to done pulse; kill aborts in flight.
module nios_ii_system_cpu_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_div_start,
  input  logic        M_div_signed,
  input  logic [31:0] M_div_src1,
  input  logic [31:0] M_div_src2,
  input  logic        M_div_kill,
  output logic        M_div_busy,
  output logic        M_div_done,
  output logic [31:0] M_div_quotient,
  output logic [31:0] M_div_remainder
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rmd_q, rmd_d;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        sgn1;
  logic        sgn2;

  assign sgn1    = M_div_signed & M_div_src1[31];
  assign sgn2    = M_div_signed & M_div_src2[31];
  assign abs1    = sgn1 ? 32'd0 - M_div_src1 : M_div_src1;
  assign abs2    = sgn2 ? 32'd0 - M_div_src2 : M_div_src2;
  assign shifted = {rem_q, dvd_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    unique case (state_q)
      S_IDLE: begin
        if (M_div_start && !M_div_kill) begin
          state_d = S_CALC;
          cnt_d   = 5'd0;
          dvd_d   = abs1;
          dvs_d   = abs2;
          rem_d   = 32'd0;
          // x/0 leaves quotient all-ones; remainder sign fix restores src1
          negq_d  = (sgn1 ^ sgn2) & (M_div_src2 != 32'd0);
          negr_d  = sgn1;
        end
      end
      S_CALC: begin
        if (M_div_kill) begin
          state_d = S_IDLE;
        end else begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
          end else begin
            rem_d = shifted[31:0];
          end
          dvd_d = {dvd_q[30:0], ~trial[32]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (M_div_kill) begin
          state_d = S_IDLE;
        end else begin
          quo_d   = negq_q ? 32'd0 - dvd_q : dvd_q;
          rmd_d   = negr_q ? 32'd0 - rem_q : rem_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= 32'd0;
      rmd_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign M_div_busy      = busy_q;
  assign M_div_done      = done_q;
  assign M_div_quotient  = quo_q;
  assign M_div_remainder = rmd_q;

endmodule

// File: tb/tb_nios_ii_system_cpu_div_cell.sv
// Bench for nios_ii_system_cpu_div_cell: directed table, random ops vs
// arithmetic model, kill/reset/held-start sequences.
module tb_nios_ii_system_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_div_start = 1'b0;
  logic        M_div_signed = 1'b0;
  logic [31:0] M_div_src1 = 32'd0;
  logic [31:0] M_div_src2 = 32'd0;
  logic        M_div_kill = 1'b0;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_quotient;
  logic [31:0] M_div_remainder;

  nios_ii_system_cpu_div_cell dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .M_div_start     (M_div_start),
    .M_div_signed    (M_div_signed),
    .M_div_src1      (M_div_src1),
    .M_div_src2      (M_div_src2),
    .M_div_kill      (M_div_kill),
    .M_div_busy      (M_div_busy),
    .M_div_done      (M_div_done),
    .M_div_quotient  (M_div_quotient),
    .M_div_remainder (M_div_remainder)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input bit sgn, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  task automatic run_op(input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold_until,
                        input int kill_at,
                        output logic [31:0] q, output logic [31:0] r,
                        output int ndone, output int first,
                        output int nbusy);
    ndone = 0;
    first = -1;
    nbusy = 0;
    q = '0;
    r = '0;
    @(negedge clk);
    M_div_start  = 1'b1;
    M_div_signed = sgn;
    M_div_src1   = a;
    M_div_src2   = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (M_div_busy) nbusy++;
      if (M_div_done) begin
        ndone++;
        if (first < 0) begin
          first = k;
          q = M_div_quotient;
          r = M_div_remainder;
        end
      end
      if (k >= hold_until) M_div_start = 1'b0;
      M_div_kill = (k == kill_at);
    end
    M_div_start = 1'b0;
    M_div_kill  = 1'b0;
  endtask

  task automatic op_check(input string nm, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold_until);
    logic [31:0] eq, er, q, r;
    int nd, fd, nb;
    model(sgn, a, b, eq, er);
    run_op(sgn, a, b, hold_until, 0, q, r, nd, fd, nb);
    chk({nm, " quo"}, q, eq);
    chk({nm, " rem"}, r, er);
    chk({nm, " lat"}, 32'(fd), 32'd34);
    chk({nm, " ndone"}, 32'(nd), 32'd1);
    chk({nm, " nbusy"}, 32'(nb), 32'd34);
    chk({nm, " hold q"}, M_div_quotient, eq);
  endtask

  vec_t vt[$];

  initial begin
    logic [31:0] q, r, a, b;
    int nd, fd, nb;
    bit sgn;

    vt.push_back('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2});
    vt.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vt.push_back('{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1});
    vt.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0});
    vt.push_back('{1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF});
    vt.push_back('{1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678});
    vt.push_back('{1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678});
    vt.push_back('{1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00});
    vt.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000});
    vt.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE});

    #1;
    chk("rst busy", 32'(M_div_busy), 32'd0);
    chk("rst done", 32'(M_div_done), 32'd0);
    chk("rst quo", M_div_quotient, 32'd0);
    chk("rst rem", M_div_remainder, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      run_op(vt[i].sgn, vt[i].a, vt[i].b, 1, 0, q, r, nd, fd, nb);
      chk($sformatf("tbl%0d quo", i), q, vt[i].q);
      chk($sformatf("tbl%0d rem", i), r, vt[i].r);
      chk($sformatf("tbl%0d lat", i), 32'(fd), 32'd34);
      chk($sformatf("tbl%0d ndone", i), 32'(nd), 32'd1);
      chk($sformatf("tbl%0d nbusy", i), 32'(nb), 32'd34);
    end

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom() >> $urandom_range(0, 24);
      endcase
      op_check($sformatf("rnd%0d", i), sgn, a, b, 1);
    end

    // start+kill together in idle must be ignored
    op_check("pre", 1'b0, 32'd1000, 32'd3, 1);
    @(negedge clk);
    M_div_start = 1'b1;
    M_div_kill  = 1'b1;
    M_div_src1  = 32'd9;
    M_div_src2  = 32'd2;
    @(negedge clk);
    M_div_start = 1'b0;
    M_div_kill  = 1'b0;
    chk("startkill busy", 32'(M_div_busy), 32'd0);

    run_op(1'b0, 32'd5, 32'd1, 1, 10, q, r, nd, fd, nb);
    chk("kill10 ndone", 32'(nd), 32'd0);
    chk("kill10 nbusy", 32'(nb), 32'd10);
    chk("kill10 quo", M_div_quotient, 32'd333);
    chk("kill10 rem", M_div_remainder, 32'd1);
    op_check("postkill", 1'b0, 32'd100, 32'd7, 1);

    run_op(1'b0, 32'd50, 32'd6, 1, 33, q, r, nd, fd, nb);
    chk("killfix ndone", 32'(nd), 32'd0);
    chk("killfix nbusy", 32'(nb), 32'd33);
    chk("killfix quo", M_div_quotient, 32'd14);
    chk("killfix rem", M_div_remainder, 32'd2);

    run_op(1'b0, 32'd50, 32'd6, 1, 34, q, r, nd, fd, nb);
    chk("killdone ndone", 32'(nd), 32'd1);
    chk("killdone quo", q, 32'd8);
    chk("killdone rem", r, 32'd2);

    op_check("held", 1'b1, 32'hFFFF_FF9C, 32'd7, 33);

    @(negedge clk);
    M_div_start  = 1'b1;
    M_div_signed = 1'b0;
    M_div_src1   = 32'd77;
    M_div_src2   = 32'd5;
    @(negedge clk);
    M_div_start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst busy", 32'(M_div_busy), 32'd0);
    chk("midrst done", 32'(M_div_done), 32'd0);
    chk("midrst quo", M_div_quotient, 32'd0);
    chk("midrst rem", M_div_remainder, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (M_div_done) nd++;
    end
    chk("midrst ndone", 32'(nd), 32'd0);
    op_check("postrst", 1'b0, 32'd100, 32'd7, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
